// File: rtl/sdhci_obi_responder.sv
// OBI subordinate front end for the SDHCI register file: one outstanding
// transaction, address decode, stallable register port with timeout abort.

package sdhci_obi_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module sdhci_obi_responder #(
  parameter type         obi_req_t     = sdhci_obi_pkg::obi_req_t,
  parameter type         obi_rsp_t     = sdhci_obi_pkg::obi_rsp_t,
  parameter logic [31:0] BaseAddr      = 32'h0,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    obi_req_i,
  output obi_rsp_t    obi_rsp_o,
  output logic        reg_req_o,
  output logic [7:0]  reg_addr_o,
  output logic        reg_we_o,
  output logic [3:0]  reg_be_o,
  output logic [31:0] reg_wdata_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_ready_i,
  input  logic        reg_error_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_e;

  localparam logic [7:0] TmoLast = 8'(TimeoutCycles - 1);

  state_e      state_q;
  obi_rsp_t    rsp_q;
  logic        req_q;
  logic [7:0]  addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt_q;

  logic [31:0] off_d;
  logic        dec_err_d;
  logic        no_access_d;
  logic        gnt_d;

  // Grant is gated by reset so a request held across reset is never granted.
  always_comb begin
    off_d       = obi_req_i.a.addr - BaseAddr;
    dec_err_d   = (off_d[31:8] != 24'd0) || (obi_req_i.a.addr[1:0] != 2'b00);
    no_access_d = obi_req_i.a.we && (obi_req_i.a.be == 4'b0000);
    gnt_d       = rst_ni && obi_req_i.req && (state_q == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rsp_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= 8'h00;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_q.rvalid <= 1'b0;
          if (gnt_d) begin
            addr_q      <= off_d[7:0] & 8'hFC;
            we_q        <= obi_req_i.a.we;
            be_q        <= obi_req_i.a.be;
            wdata_q     <= obi_req_i.a.wdata;
            rsp_q.r.rid <= obi_req_i.a.aid;
            if (dec_err_d) begin
              rsp_q.rvalid  <= 1'b1;
              rsp_q.r.err   <= 1'b1;
              rsp_q.r.rdata <= 32'h0;
              state_q       <= RESPOND;
            end else if (no_access_d) begin
              rsp_q.rvalid  <= 1'b1;
              rsp_q.r.err   <= 1'b0;
              rsp_q.r.rdata <= 32'h0;
              state_q       <= RESPOND;
            end else begin
              req_q   <= 1'b1;
              cnt_q   <= 8'h00;
              state_q <= ACCESS;
            end
          end
        end

        // A ready arriving in the last allowed cycle still completes normally.
        ACCESS: begin
          if (reg_ready_i) begin
            req_q         <= 1'b0;
            rsp_q.rvalid  <= 1'b1;
            rsp_q.r.err   <= reg_error_i;
            rsp_q.r.rdata <= we_q ? 32'h0 : reg_rdata_i;
            state_q       <= RESPOND;
          end else if (cnt_q == TmoLast) begin
            req_q         <= 1'b0;
            rsp_q.rvalid  <= 1'b1;
            rsp_q.r.err   <= 1'b1;
            rsp_q.r.rdata <= 32'h0;
            state_q       <= RESPOND;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        RESPOND: begin
          rsp_q.rvalid <= 1'b0;
          state_q      <= IDLE;
        end

        default: begin
          req_q        <= 1'b0;
          rsp_q.rvalid <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    obi_rsp_o     = rsp_q;
    obi_rsp_o.gnt = gnt_d;
  end

  assign reg_req_o   = req_q;
  assign reg_addr_o  = addr_q;
  assign reg_we_o    = we_q;
  assign reg_be_o    = be_q;
  assign reg_wdata_o = wdata_q;

`ifndef SYNTHESIS
  a_no_gnt_with_rvalid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(obi_rsp_o.gnt && obi_rsp_o.rvalid));
  a_rvalid_single : assert property (@(posedge clk_i) disable iff (!rst_ni)
    obi_rsp_o.rvalid |=> !obi_rsp_o.rvalid);
`endif

endmodule

// File: tb/tb_sdhci_obi_responder.sv
// Randomized self-checking bench for sdhci_obi_responder with a transaction-level model.

module tb_sdhci_obi_responder;
  import sdhci_obi_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int          TMO  = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  obi_req_t    req_s;
  obi_rsp_t    rsp_s;
  logic        reg_req_o;
  logic [7:0]  reg_addr_o;
  logic        reg_we_o;
  logic [3:0]  reg_be_o;
  logic [31:0] reg_wdata_o;
  logic [31:0] reg_rdata_i = 32'h0;
  logic        reg_ready_i = 1'b0;
  logic        reg_error_i = 1'b0;

  int checks = 0;
  int errors = 0;

  sdhci_obi_responder #(
    .obi_req_t    (obi_req_t),
    .obi_rsp_t    (obi_rsp_t),
    .BaseAddr     (BASE),
    .TimeoutCycles(TMO)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .obi_req_i  (req_s),
    .obi_rsp_o  (rsp_s),
    .reg_req_o  (reg_req_o),
    .reg_addr_o (reg_addr_o),
    .reg_we_o   (reg_we_o),
    .reg_be_o   (reg_be_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_rdata_i(reg_rdata_i),
    .reg_ready_i(reg_ready_i),
    .reg_error_i(reg_error_i)
  );

  initial forever #5 clk_i = ~clk_i;

  // Transaction-level expectation: which path the transaction takes and what it returns.
  function automatic void model(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                input int delay, input logic [31:0] rd, input logic rerr,
                                output int n_req, output int lat, output logic [31:0] e_rdata,
                                output logic e_err, output bit chk_rdata);
    longint off;
    off = longint'(addr) - longint'(BASE);
    if (off < 0 || off >= 256 || addr[1:0] != 2'b00) begin
      n_req = 0; lat = 1; e_rdata = 32'h0; e_err = 1'b1; chk_rdata = 1;
    end else if (we && be == 4'b0000) begin
      n_req = 0; lat = 1; e_rdata = 32'h0; e_err = 1'b0; chk_rdata = 0;
    end else if (delay < TMO) begin
      n_req = delay + 1; lat = n_req + 1; e_rdata = we ? 32'h0 : rd; e_err = rerr; chk_rdata = 1;
    end else begin
      n_req = TMO; lat = TMO + 1; e_rdata = 32'h0; e_err = 1'b1; chk_rdata = 1;
    end
  endfunction

  task automatic drive_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [3:0] aid);
    req_s.req     = 1'b1;
    req_s.a.addr  = addr;
    req_s.a.we    = we;
    req_s.a.be    = be;
    req_s.a.wdata = wdata;
    req_s.a.aid   = aid;
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [3:0] aid, input int delay,
                         input logic [31:0] rd, input logic rerr, input string name);
    int n_req, lat, cyc, nreq;
    logic [31:0] e_rdata, o;
    logic e_err;
    bit chk_rdata, got, unstable;
    model(addr, we, be, delay, rd, rerr, n_req, lat, e_rdata, e_err, chk_rdata);
    o = addr - BASE;
    @(negedge clk_i);
    drive_req(addr, we, be, wdata, aid);
    #1;
    checks++;
    if (rsp_s.gnt !== 1'b1 || rsp_s.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s grant: gnt=%b rvalid=%b, required gnt=1 rvalid=0", name, rsp_s.gnt, rsp_s.rvalid);
    end
    @(negedge clk_i);
    req_s.req = 1'b0;
    cyc = 1; nreq = 0; got = 0; unstable = 0;
    while (!got && cyc < 300) begin
      if (reg_req_o === 1'b1) begin
        nreq++;
        if ({reg_addr_o, reg_we_o, reg_be_o, reg_wdata_o} !== {o[7:0], we, be, wdata}) unstable = 1;
        if (nreq == delay + 1) begin
          reg_ready_i = 1'b1; reg_rdata_i = rd; reg_error_i = rerr;
        end else begin
          reg_ready_i = 1'b0; reg_rdata_i = $urandom; reg_error_i = 1'($urandom_range(0, 1));
        end
      end else begin
        reg_ready_i = 1'b0;
      end
      if (rsp_s.rvalid === 1'b1) got = 1;
      else begin
        @(negedge clk_i);
        cyc++;
      end
    end
    reg_ready_i = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s no_response: rvalid never seen within 300 cycles", name);
    end else begin
      checks++;
      if (cyc != lat) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, lat);
      end
      checks++;
      if (nreq != n_req) begin
        errors++;
        $display("FAIL %s reg_req_cycles: got %0d, required %0d", name, nreq, n_req);
      end
      checks++;
      if (unstable) begin
        errors++;
        $display("FAIL %s reg_fields: reg_* outputs differed from addr=%h we=%b be=%h wdata=%h",
                 name, o[7:0], we, be, wdata);
      end
      checks++;
      if (rsp_s.r.err !== e_err || rsp_s.r.rid !== aid) begin
        errors++;
        $display("FAIL %s err_rid: err=%b rid=%h, required err=%b rid=%h",
                 name, rsp_s.r.err, rsp_s.r.rid, e_err, aid);
      end
      if (chk_rdata) begin
        checks++;
        if (rsp_s.r.rdata !== e_rdata) begin
          errors++;
          $display("FAIL %s rdata: got %h, required %h", name, rsp_s.r.rdata, e_rdata);
        end
      end
      @(negedge clk_i);
      checks++;
      if (rsp_s.rvalid !== 1'b0 || reg_req_o !== 1'b0) begin
        errors++;
        $display("FAIL %s rvalid_pulse: rvalid=%b reg_req=%b after response, required 0 0",
                 name, rsp_s.rvalid, reg_req_o);
      end
    end
  endtask

  task automatic test_reset;
    req_s = '0;
    req_s.req = 1'b1;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (rsp_s !== '0 || reg_req_o !== 1'b0 || reg_addr_o !== 8'h0 || reg_we_o !== 1'b0 ||
        reg_be_o !== 4'h0 || reg_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rsp=%h req=%b addr=%h we=%b be=%h wdata=%h, required all 0",
               rsp_s, reg_req_o, reg_addr_o, reg_we_o, reg_be_o, reg_wdata_o);
    end
    req_s.req = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_write_min;
    run_txn(BASE + 32'h34, 1'b1, 4'b1111, 32'hFFFF_0001, 4'h1, 0, 32'h0, 1'b0, "write_min");
  endtask

  task automatic test_read_stall;
    run_txn(BASE + 32'h30, 1'b0, 4'b1111, 32'h0, 4'h3, 5, 32'h0001_0002, 1'b0, "read_stall");
    run_txn(BASE + 32'h30, 1'b0, 4'b0001, 32'h0, 4'h9, 2, 32'hDEAD_BEEF, 1'b1, "read_regerr");
  endtask

  task automatic test_timeout;
    run_txn(BASE + 32'h20, 1'b0, 4'b1111, 32'h0, 4'h2, 1000, 32'h1234_5678, 1'b0, "timeout");
    run_txn(BASE + 32'h20, 1'b0, 4'b1111, 32'h0, 4'h4, TMO - 1, 32'h8765_4321, 1'b0, "ready_at_limit");
  endtask

  task automatic test_decode_err;
    run_txn(BASE + 32'h100, 1'b0, 4'b1111, 32'h0, 4'h6, 0, 32'h1, 1'b0, "out_of_window");
    run_txn(BASE + 32'h02E, 1'b1, 4'b1111, 32'h5, 4'h7, 0, 32'h1, 1'b0, "misaligned");
    run_txn(BASE - 32'h4, 1'b0, 4'b1111, 32'h0, 4'h8, 0, 32'h1, 1'b0, "below_base");
  endtask

  task automatic test_held;
    @(negedge clk_i);
    drive_req(BASE + 32'h0C, 1'b1, 4'b0000, 32'hAAAA_5555, 4'hA);
    #1;
    checks++;
    if (rsp_s.gnt !== 1'b1) begin
      errors++;
      $display("FAIL held_first_gnt: gnt=%b, required 1", rsp_s.gnt);
    end
    @(negedge clk_i);
    drive_req(BASE + 32'h10, 1'b0, 4'b1111, 32'h0, 4'h5);
    #1;
    checks++;
    if (rsp_s.rvalid !== 1'b1 || rsp_s.r.err !== 1'b0 || rsp_s.r.rid !== 4'hA ||
        rsp_s.gnt !== 1'b0 || reg_req_o !== 1'b0) begin
      errors++;
      $display("FAIL held_respond: rvalid=%b err=%b rid=%h gnt=%b reg_req=%b, required 1 0 a 0 0",
               rsp_s.rvalid, rsp_s.r.err, rsp_s.r.rid, rsp_s.gnt, reg_req_o);
    end
    run_txn(BASE + 32'h10, 1'b0, 4'b1111, 32'h0, 4'h5, 2, 32'hCAFE_0010, 1'b0, "held_read");
  endtask

  task automatic test_reset_mid;
    bit bad;
    @(negedge clk_i);
    drive_req(BASE + 32'h24, 1'b0, 4'b1111, 32'h0, 4'h7);
    @(negedge clk_i);
    req_s.req = 1'b0;
    reg_ready_i = 1'b0;
    checks++;
    if (reg_req_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_access: reg_req=%b, required 1", reg_req_o);
    end
    repeat (2) @(negedge clk_i);
    req_s.req = 1'b1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (reg_req_o !== 1'b0 || rsp_s.gnt !== 1'b0 || rsp_s.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: reg_req=%b gnt=%b rvalid=%b, required 0 0 0",
               reg_req_o, rsp_s.gnt, rsp_s.rvalid);
    end
    @(negedge clk_i);
    req_s.req = 1'b0;
    rst_ni = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (rsp_s.rvalid !== 1'b0 || reg_req_o !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_quiet: activity after reset release, required none");
    end
    run_txn(BASE + 32'h24, 1'b0, 4'b1111, 32'h0, 4'hB, 1, 32'h0BAD_F00D, 1'b0, "after_reset");
  endtask

  task automatic test_random;
    logic [31:0] addr;
    int sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      addr = BASE + ($urandom_range(0, 63) << 2);
      else if (sel == 7) addr = BASE + 32'd256 + $urandom_range(0, 1000);
      else if (sel == 8) addr = BASE + ($urandom_range(0, 255) | 1);
      else               addr = BASE - $urandom_range(1, 4096);
      run_txn(addr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 19), $urandom,
              1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_min();
    test_read_stall();
    test_timeout();
    test_decode_err();
    test_held();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
